// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU datapath: widths, opcodes, the
// divide-by-zero result and the pipeline payload structs.
// Optional feature macro: ALU_STATUS_FLAGS_EN adds zero/negative status bits
// to the writeback payload.
package cpu19_pkg;

    localparam int unsigned DATA_W = 19;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned IMM_W  = 10;
    localparam int unsigned RD_W   = 3;

    localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OPC_W-1:0] OP_MUL = 5'b00010;
    localparam logic [OPC_W-1:0] OP_DIV = 5'b00011;
    localparam logic [OPC_W-1:0] OP_MAC = 5'b01000;

    localparam logic [DATA_W-1:0] DIV0_RESULT = 19'h7FFFF;

    // EX register contents; opcode is already remapped for the ALU, so the
    // MAC marker has to travel separately
    typedef struct packed {
        logic              is_mac;
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [IMM_W-1:0]  imm;
        logic [RD_W-1:0]   rd;
    } ex_pay_t;

    // WB register contents
    typedef struct packed {
`ifdef ALU_STATUS_FLAGS_EN
        logic              zero;
        logic              neg;
`endif
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_pay_t;

    // The ALU has no MAC operation; it computes the product and the stage adds the accumulator
    function automatic logic [OPC_W-1:0] alu_opc_map(input logic [OPC_W-1:0] opc);
        return (opc == OP_MAC) ? OP_MUL : opc;
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// Single-entry valid/ready register slice with a parameterised payload.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream. in_ready is combinational from
// the slice state and out_ready, which allows one transfer per cycle.
module pipe_slice #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic load;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Payload loads on an upstream transfer and is held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/writeback stage around the external combinational 19-bit ALU.
// EX slice registers the decoded instruction and feeds the ALU; WB slice
// captures the result for the register file. The stage owns the MAC
// accumulator and the sticky divide-by-zero flag.
// Ports: clk, rst (async, active high); in_* upstream instruction with
// valid/ready; acc_clr accumulator clear; alu_* to/from the ALU; wb_*
// writeback with valid/ready; div0 sticky flag; acc accumulator value.
// Optional feature macro: ALU_STATUS_FLAGS_EN adds wb_zero and wb_neg.
module alu_exec_stage
    import cpu19_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [IMM_W-1:0]  alu_imm,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
`ifdef ALU_STATUS_FLAGS_EN
    output logic              wb_zero,
    output logic              wb_neg,
`endif
    output logic              div0,
    output logic [DATA_W-1:0] acc
);

    localparam int unsigned EX_W = $bits(ex_pay_t);
    localparam int unsigned WB_W = $bits(wb_pay_t);

    ex_pay_t           ex_d;
    ex_pay_t           ex_q;
    wb_pay_t           wb_d;
    wb_pay_t           wb_q;
    logic              ex_valid;
    logic              wb_adv;
    logic              ex_adv;
    logic              div_by_zero;
    logic [DATA_W-1:0] acc_eff;
    logic [DATA_W-1:0] mac_sum;

    // Instruction fields as they enter EX
    always_comb begin
        ex_d        = '0;
        ex_d.is_mac = (in_opcode == OP_MAC);
        ex_d.opcode = alu_opc_map(in_opcode);
        ex_d.a      = in_a;
        ex_d.b      = in_b;
        ex_d.imm    = in_imm;
        ex_d.rd     = in_rd;
    end

    pipe_slice #(.W(EX_W)) u_ex (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (ex_d),
        .out_valid(ex_valid),
        .out_ready(wb_adv),
        .out_data (ex_q)
    );

    assign ex_adv = ex_valid && wb_adv;

    // Result selection for the instruction leaving EX
    always_comb begin
        acc_eff     = acc_clr ? '0 : acc;
        mac_sum     = alu_result + acc_eff;
        div_by_zero = (ex_q.opcode == OP_DIV) && (ex_q.b == '0);
        wb_d        = '0;
        wb_d.rd     = ex_q.rd;
        if (ex_q.is_mac) begin
            wb_d.data = mac_sum;
        end else if (div_by_zero) begin
            wb_d.data = DIV0_RESULT;
        end else begin
            wb_d.data = alu_result;
        end
`ifdef ALU_STATUS_FLAGS_EN
        wb_d.zero = (wb_d.data == '0);
        wb_d.neg  = wb_d.data[DATA_W-1];
`endif
    end

    pipe_slice #(.W(WB_W)) u_wb (
        .clk      (clk),
        .rst      (rst),
        .in_valid (ex_valid),
        .in_ready (wb_adv),
        .in_data  (wb_d),
        .out_valid(wb_valid),
        .out_ready(wb_ready),
        .out_data (wb_q)
    );

    // Accumulator: a MAC retiring this cycle already folded in any clear via acc_eff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (ex_adv && ex_q.is_mac) begin
            acc <= mac_sum;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    // Sticky divide-by-zero flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div0 <= 1'b0;
        end else if (ex_adv && div_by_zero) begin
            div0 <= 1'b1;
        end
    end

    assign alu_a      = ex_q.a;
    assign alu_b      = ex_q.b;
    assign alu_opcode = ex_q.opcode;
    assign alu_imm    = ex_q.imm;
    assign wb_rd      = wb_q.rd;
    assign wb_data    = wb_q.data;
`ifdef ALU_STATUS_FLAGS_EN
    assign wb_zero    = wb_q.zero;
    assign wb_neg     = wb_q.neg;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: bench-owned ALU stub, a
// transaction-level reference model checked every cycle, directed literal
// checks and a randomized phase.
module tb_alu_exec_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [18:0] in_a;
    logic [18:0] in_b;
    logic [9:0]  in_imm;
    logic [2:0]  in_rd;
    logic        acc_clr;
    logic [18:0] alu_a;
    logic [18:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [9:0]  alu_imm;
    logic [18:0] alu_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_rd;
    logic [18:0] wb_data;
    logic        div0;
    logic [18:0] acc;
`ifdef ALU_STATUS_FLAGS_EN
    logic        wb_zero;
    logic        wb_neg;
`endif

    int total = 0;
    int bad   = 0;

    alu_exec_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_imm    (in_imm),
        .in_rd     (in_rd),
        .acc_clr   (acc_clr),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_opcode(alu_opcode),
        .alu_imm   (alu_imm),
        .alu_result(alu_result),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
`ifdef ALU_STATUS_FLAGS_EN
        .wb_zero   (wb_zero),
        .wb_neg    (wb_neg),
`endif
        .div0      (div0),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple combinational ALU used both as the DUT's ALU and by the model
    function automatic logic [18:0] alu_fn(input logic [4:0] op, input logic [18:0] a,
                                           input logic [18:0] b, input logic [9:0] imm);
        logic [18:0] s;
        s = {{9{imm[9]}}, imm};
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a * b;
            5'd3:    return (b == 19'd0) ? 19'd0 : a / b;
            5'd4:    return a & b;
            5'd5:    return a | b;
            5'd6:    return a ^ b;
            5'd7:    return a + s;
            default: return 19'd0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_opcode, alu_a, alu_b, alu_imm);

    typedef struct {
        logic [4:0]  op;
        logic [18:0] a;
        logic [18:0] b;
        logic [9:0]  imm;
        logic [2:0]  rd;
    } ins_t;

    // Architectural result of one instruction given accumulator and clear
    function automatic logic [18:0] exp_result(input ins_t it, input logic [18:0] accv,
                                               input logic clr);
        if (it.op == 5'b01000)
            return alu_fn(5'b00010, it.a, it.b, it.imm) + (clr ? 19'd0 : accv);
        if (it.op == 5'b00011 && it.b == 19'd0)
            return 19'h7FFFF;
        return alu_fn(it.op, it.a, it.b, it.imm);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-order instruction queue, accumulator and div0
    ins_t        q[$];
    ins_t        s_ins;
    ins_t        it;
    logic [18:0] m_acc = '0;
    logic        m_div0 = 1'b0;
    logic [18:0] last_exp = '0;
    logic [18:0] e;
    logic        s_wbv = 1'b0;
    logic        s_wbr = 1'b0;
    logic        s_clr = 1'b0;
    logic        s_take = 1'b0;

    // Compare process: at each negedge, account for the edge just passed
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_acc  = '0;
            m_div0 = 1'b0;
            s_wbv  = 1'b0;
            s_wbr  = 1'b0;
            s_clr  = 1'b0;
            s_take = 1'b0;
        end else begin
            if ((!s_wbv || s_wbr) && wb_valid) begin
                if (q.size() == 0) begin
                    chk("wb_spurious", 32'(wb_valid), 32'd0);
                end else begin
                    it = q.pop_front();
                    e  = exp_result(it, m_acc, s_clr);
                    chk("wb_data", 32'(wb_data), 32'(e));
                    chk("wb_rd", 32'(wb_rd), 32'(it.rd));
`ifdef ALU_STATUS_FLAGS_EN
                    chk("wb_zero", 32'(wb_zero), 32'(e == 19'd0));
                    chk("wb_neg", 32'(wb_neg), 32'(e[18]));
`endif
                    if (it.op == 5'b01000) m_acc = e;
                    else if (s_clr) m_acc = '0;
                    if (it.op == 5'b00011 && it.b == 19'd0) m_div0 = 1'b1;
                    last_exp = e;
                end
            end else begin
                if (s_clr) m_acc = '0;
                if (s_wbv && !s_wbr) begin
                    chk("wb_hold_valid", 32'(wb_valid), 32'd1);
                    chk("wb_hold_data", 32'(wb_data), 32'(last_exp));
                end
            end
            chk("acc", 32'(acc), 32'(m_acc));
            chk("div0", 32'(div0), 32'(m_div0));
            if (wb_ready) chk("in_ready_free", 32'(in_ready), 32'd1);
            if (alu_opcode == 5'b01000) chk("alu_opc_remap", 32'(alu_opcode), 32'd2);
            if (s_take) q.push_back(s_ins);
            s_wbv    = wb_valid;
            s_wbr    = wb_ready;
            s_clr    = acc_clr;
            s_take   = in_valid && in_ready;
            s_ins.op  = in_opcode;
            s_ins.a   = in_a;
            s_ins.b   = in_b;
            s_ins.imm = in_imm;
            s_ins.rd  = in_rd;
        end
    end

    task automatic drive(input logic [4:0] op, input logic [18:0] a, input logic [18:0] b,
                         input logic [9:0] imm, input logic [2:0] rd);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_imm    = imm;
        in_rd     = rd;
    endtask

    // Present one instruction until accepted; returns at posedge+1 with it in EX
    task automatic issue(input logic [4:0] op, input logic [18:0] a, input logic [18:0] b,
                         input logic [9:0] imm, input logic [2:0] rd);
        logic ok;
        drive(op, a, b, imm, rd);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("issue_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the next downstream transfer and return its data
    task automatic wait_wb(output logic [18:0] d);
        logic got;
        got = 1'b0;
        d   = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (wb_valid && wb_ready) begin
                got = 1'b1;
                d   = wb_data;
            end
        end
        if (!got) chk("wb_timeout", 32'd0, 32'd1);
    endtask

    task automatic run1(input string name, input logic [4:0] op, input logic [18:0] a,
                        input logic [18:0] b, input logic [18:0] exp);
        logic [18:0] d;
        issue(op, a, b, 10'd0, 3'd5);
        if (op == 5'b01000) chk({name, "_aluopc"}, 32'(alu_opcode), 32'd2);
        wait_wb(d);
        chk(name, 32'(d), 32'(exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] d;
        logic        tk;
        int          r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        in_imm    = '0;
        in_rd     = '0;
        acc_clr   = 1'b0;
        wb_ready  = 1'b1;
        #12;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_opc", 32'(alu_opcode), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Back-to-back adds
        drive(5'd0, 19'd5, 19'd7, 10'd0, 3'd1);
        @(negedge clk); chk("b2b_rdy0", 32'(in_ready), 32'd1);
        @(posedge clk); #1 drive(5'd0, 19'd100, 19'd1, 10'd0, 3'd2);
        @(negedge clk); chk("b2b_rdy1", 32'(in_ready), 32'd1);
        chk("b2b_notyet", 32'(wb_valid), 32'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk("b2b_v0", 32'(wb_valid), 32'd1);
        chk("b2b_d0", 32'(wb_data), 32'd12);
        @(negedge clk); chk("b2b_v1", 32'(wb_valid), 32'd1);
        chk("b2b_d1", 32'(wb_data), 32'd101);
        idle(3);

        // Backpressure
        wb_ready = 1'b0;
        drive(5'd0, 19'd1, 19'd1, 10'd0, 3'd1);
        @(negedge clk); chk("bp_rdy0", 32'(in_ready), 32'd1);
        @(posedge clk); #1 drive(5'd0, 19'd2, 19'd2, 10'd0, 3'd2);
        @(negedge clk); chk("bp_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk); #1 drive(5'd0, 19'd3, 19'd3, 10'd0, 3'd3);
        @(negedge clk); chk("bp_rdy2", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_stall_rdy", 32'(in_ready), 32'd0);
        chk("bp_stall_d", 32'(wb_data), 32'd2);
        @(posedge clk); #1 wb_ready = 1'b1;
        @(negedge clk); chk("bp_rel_rdy", 32'(in_ready), 32'd1);
        chk("bp_rel_d0", 32'(wb_data), 32'd2);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk("bp_d1", 32'(wb_data), 32'd4);
        @(negedge clk); chk("bp_d2", 32'(wb_data), 32'd6);
        idle(3);

        // MAC chain
        acc_clr = 1'b1;
        idle(1);
        acc_clr = 1'b0;
        run1("mac1", 5'b01000, 19'd3, 19'd4, 19'd12);
        run1("mac2", 5'b01000, 19'd2, 19'd5, 19'd22);
        chk("mac_acc22", 32'(acc), 32'd22);
        // MAC with a clear in its execute cycle
        issue(5'b01000, 19'd1, 19'd1, 10'd0, 3'd4);
        acc_clr = 1'b1;
        @(posedge clk); #1 acc_clr = 1'b0;
        wait_wb(d);
        chk("mac_clr", 32'(d), 32'd1);
        chk("mac_clr_acc", 32'(acc), 32'd1);
        idle(2);

        // Divide by zero
        run1("div0_res", 5'b00011, 19'd50, 19'd0, 19'h7FFFF);
        idle(1);
        chk("div0_set", 32'(div0), 32'd1);
        run1("div_ok", 5'b00011, 19'd50, 19'd5, 19'd10);
        idle(1);
        chk("div0_sticky", 32'(div0), 32'd1);
        run1("addi_neg", 5'd7, 19'd10, 19'd0, 19'd10);
        idle(2);

        // Randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            tk = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || tk) begin
                if ($urandom_range(0, 9) < 7) begin
                    r = int'($urandom_range(0, 10));
                    in_valid  = 1'b1;
                    in_a      = 19'($urandom);
                    in_b      = ($urandom_range(0, 3) == 0) ? 19'($urandom_range(0, 15)) : 19'($urandom);
                    in_imm    = 10'($urandom);
                    in_rd     = 3'($urandom);
                    if (r < 8) in_opcode = 5'(r);
                    else if (r == 8) in_opcode = 5'b01000;
                    else if (r == 9) begin in_opcode = 5'b00011; in_b = 19'd0; end
                    else in_opcode = ($urandom_range(0, 1) == 0) ? 5'h1F : 5'h10;
                end else begin
                    in_valid = 1'b0;
                end
            end
            wb_ready = ($urandom_range(0, 9) < 7);
            acc_clr  = ($urandom_range(0, 9) == 0);
        end
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        wb_ready = 1'b1;
        idle(8);
        chk("drain_empty", 32'(q.size()), 32'd0);

        // Async reset during a stall with a result pending
        acc_clr = 1'b1;
        idle(1);
        acc_clr = 1'b0;
        run1("mac_pre", 5'b01000, 19'd3, 19'd3, 19'd9);
        idle(1);
        wb_ready = 1'b0;
        issue(5'd0, 19'd1, 19'd2, 10'd0, 3'd6);
        idle(2);
        chk("pre_rst_wbv", 32'(wb_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_wbv", 32'(wb_valid), 32'd0);
        chk("arst_acc", 32'(acc), 32'd0);
        chk("arst_div0", 32'(div0), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 32'(in_ready), 32'd1);
        chk("post_rst_wbv", 32'(wb_valid), 32'd0);
        wb_ready = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/writeback pipeline stage wrapped around the combinational 19-bit ALU.
- Accepts decoded instructions from the operand-fetch stage through a valid/ready handshake and registers the operands (EX).
- Drives the ALU from those registers, then captures the result into a writeback register (WB) for the register file.
- Owns the multiply-accumulate accumulator, so the ALU never needs combinational result feedback, and handles divide-by-zero.

Parameters:
- DATA_W, 19, datapath width.
- OPC_W, 5, opcode width.
- IMM_W, 10, immediate width, sign-extended by the ALU.
- RD_W, 3, destination register index width (8 registers).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_opcode  in  OPC_W  operation.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_imm  in  IMM_W  immediate.
- in_rd  in  RD_W  destination register.
- acc_clr  in  1  clear the MAC accumulator.
- alu_a  out  DATA_W  EX-registered operand A, to the ALU.
- alu_b  out  DATA_W  EX-registered operand B, to the ALU.
- alu_opcode  out  OPC_W  ALU opcode; the MAC opcode is remapped to multiply.
- alu_imm  out  IMM_W  EX-registered immediate, to the ALU.
- alu_result  in  DATA_W  combinational ALU output.
- wb_valid  out  1  writeback data valid.
- wb_ready  in  1  register file accepts.
- wb_rd  out  RD_W  destination register.
- wb_data  out  DATA_W  result.
- div0  out  1  sticky divide-by-zero flag.
- acc  out  DATA_W  current accumulator value.

Behaviour:
- Reset (async, rst=1): ex_valid=0, wb_valid=0, wb_rd=0, wb_data=0, acc=0, div0=0, all alu_* outputs 0.
  - Reset mid-operation drops in-flight instructions without writeback.
- Handshake:
  - Upstream transfer when in_valid && in_ready.
  - Downstream transfer when wb_valid && wb_ready.
  - Upstream must hold its inputs stable while in_valid && !in_ready.
- Advance rules:
  - wb_adv = !wb_valid || wb_ready.
  - ex_adv = ex_valid && wb_adv.
  - in_ready = !ex_valid || wb_adv (combinational from state and wb_ready only).
- EX register: loads the in_* fields on upstream transfer. ex_valid sets on load, clears on ex_adv with no new load. Load and ex_adv in the same cycle keeps ex_valid=1.
- WB register: loads on ex_adv; wb_valid clears on a downstream transfer with no ex_adv.
  - Latency: accept at edge N gives wb_valid at edge N+2.
  - Throughput: 1 per cycle with wb_ready held high.
  - Stalls: when wb_ready=0 the EX and WB contents are held unchanged.
- Opcode handling at ex_adv:
  - MAC (5'b01000): alu_opcode driven as 5'b00010 (multiply). wb_data = (alu_result + acc_eff) mod 2^19 and acc <= wb_data. acc_eff = 0 if acc_clr this cycle, else acc.
  - DIV (5'b00011) with alu_b==0: wb_data = 19'h7FFFF (ALU output ignored); div0 sets and stays set until reset.
  - All other opcodes: wb_data = alu_result. Undefined opcodes pass the ALU default of 0 through.
- acc_clr:
  - Without a MAC transfer, acc <= 0.
  - With a simultaneous MAC transfer, the clear applies first, so acc = product.
- Arithmetic: all sums truncate to DATA_W bits; no saturation except the divide-by-zero case.

Optional Feature:
- Macro: ALU_STATUS_FLAGS_EN.
- Defined:
  - Adds outputs wb_zero (wb_data==0) and wb_neg (wb_data[DATA_W-1]).
  - Both are registered alongside wb_data, reset to 0, and valid only when wb_valid=1.
- Undefined: the ports do not exist and there is no added logic.

Decomposition:
- Shared package cpu19_pkg:
  - DATA_W, OPC_W, IMM_W, RD_W.
  - Opcode localparams, including OP_MUL=5'b00010, OP_DIV=5'b00011, OP_MAC=5'b01000.
  - Constant DIV0_RESULT=19'h7FFFF.
- One natural sub-module: pipe_slice. It is a valid/ready register slice with parameterised payload width, instanced for both EX and WB. MAC and divide logic stays in the parent.

Test Plan:
- Add back-to-back: opcode 00000 with (5,7), then (100,1), wb_ready=1 -> wb_data 12 at cycle N+2, 101 at N+3, in_ready constant 1.
- Backpressure: wb_ready=0 for 3 cycles with 3 instructions issued -> in_ready falls after 2 accepts, no data lost, results emerge in order once wb_ready=1.
- MAC chain: acc_clr pulse, then MAC (3,4), then MAC (2,5) -> wb_data 12 then 22, acc=22; alu_opcode observed as 00010 during both.
- MAC with simultaneous acc_clr while acc=22: MAC (1,1) -> wb_data 1, acc=1.
- Divide by zero: DIV (50,0) -> wb_data 19'h7FFFF, div0=1 and sticky. DIV (50,5) afterwards -> wb_data 10, div0 still 1.
- Async reset asserted mid-stall with wb_valid=1 -> wb_valid, acc, div0 go to 0 immediately without a clock edge, in_ready=1 after release.
